seq_pattern_tx: RTL and testbench

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_pattern_tx_pkg.sv | 15 +
 rtl/seq_shift_out.sv | 58 +++++
 rtl/seq_pattern_tx.sv | 148 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_tx_pkg.sv
// Shared types and default sizing for the serial pattern transmitter.
package seq_pattern_tx_pkg;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap,
        StDone
    } state_e;

    localparam int unsigned PatWDefault = 8;
    localparam int unsigned CntWDefault = 4;

endpackage

// File: rtl/seq_shift_out.sv
// Holds the latched pattern, its length and the current bit index. Exposes the
// bit that will be on the line next cycle, so the top can register it.
module seq_shift_out #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             restart,
    input  logic             shift,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] len,
    output logic             bit_nxt,
    output logic             bit_last
);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [PAT_W-1:0] shifted;

    // Next-state for pattern, length and bit index; load wins over restart/shift.
    always_comb begin
        pat_d = pat_q;
        len_d = len_q;
        idx_d = idx_q;
        if (load) begin
            pat_d = pattern;
            len_d = len;
            idx_d = len - CNT_W'(1);
        end else if (restart) begin
            idx_d = len_q - CNT_W'(1);
        end else if (shift) begin
            idx_d = idx_q - CNT_W'(1);
        end
        // Bit addressed by the index after this edge, i.e. next cycle's line value.
        shifted = pat_d >> idx_d;
        bit_nxt = shifted[0];
    end

    // idx_q addresses the bit currently on the line; zero means last of the repetition.
    assign bit_last = (idx_q == '0);

    // Latched operand and index registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q <= '0;
            len_q <= '0;
            idx_q <= '0;
        end else begin
            pat_q <= pat_d;
            len_q <= len_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB first, repeated reps
// times with gap zero bits between repetitions. All outputs are registered.
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int unsigned PAT_W = PatWDefault,
    parameter int unsigned CNT_W = CntWDefault
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] len,
    input  logic [CNT_W-1:0] reps,
    input  logic [CNT_W-1:0] gap,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] reps_left_q, reps_left_d;
    logic [CNT_W-1:0] gap_len_q, gap_len_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             operands_ok;
    logic             ld, restart, shift, reject;
    logic             bit_nxt, bit_last;
    logic             out_d, out_valid_d, busy_d, done_d, err_d;

    assign operands_ok = (len != '0) && (32'(len) <= PAT_W) && (reps != '0);

    seq_shift_out #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (ld),
        .restart  (restart),
        .shift    (shift),
        .pattern  (pattern),
        .len      (len),
        .bit_nxt  (bit_nxt),
        .bit_last (bit_last)
    );

    // State and counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            reps_left_q <= '0;
            gap_len_q   <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            reps_left_q <= reps_left_d;
            gap_len_q   <= gap_len_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    // Next-state, counter updates and shifter control.
    always_comb begin
        state_d     = state_q;
        reps_left_d = reps_left_q;
        gap_len_d   = gap_len_q;
        gap_cnt_d   = gap_cnt_q;
        ld          = 1'b0;
        restart     = 1'b0;
        shift       = 1'b0;
        reject      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (operands_ok) begin
                        state_d     = StSend;
                        ld          = 1'b1;
                        reps_left_d = reps;
                        gap_len_d   = gap;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            StSend: begin
                if (!bit_last) begin
                    shift = 1'b1;
                end else if (reps_left_q > CNT_W'(1)) begin
                    reps_left_d = reps_left_q - CNT_W'(1);
                    if (gap_len_q != '0) begin
                        state_d   = StGap;
                        gap_cnt_d = gap_len_q;
                    end else begin
                        // Back-to-back repetition: no idle cycle.
                        restart = 1'b1;
                    end
                end else begin
                    state_d     = StDone;
                    reps_left_d = '0;
                end
            end
            StGap: begin
                if (gap_cnt_q == CNT_W'(1)) begin
                    state_d   = StSend;
                    gap_cnt_d = '0;
                    restart   = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output values for the cycle after this edge, derived from the next state.
    always_comb begin
        out_d       = (state_d == StSend) && bit_nxt;
        out_valid_d = (state_d == StSend) || (state_d == StGap);
        busy_d      = out_valid_d;
        done_d      = (state_d == StDone);
        err_d       = reject;
    end

    // Output registers; reset clears them asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            out       <= out_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx with a 111 detector model on the loopback.
module tb_seq_pattern_tx;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] reps;
    logic [3:0] gap;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    // Loopback detector model state.
    logic [1:0] hist;
    int         run_no;
    int         det_ov;
    int         det_nov;

    seq_pattern_tx #(
        .PAT_W (8),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
        .reps      (reps),
        .gap       (gap),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".out"}, 32'(out), 32'd0);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    // Drive operands with start for one cycle; returns in the first frame cycle.
    task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                        input logic [3:0] g);
        pattern = p;
        len     = l;
        reps    = r;
        gap     = g;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic feed_detector(input logic b);
        if (b) begin
            if (hist == 2'b11) det_ov++;
            hist = {hist[0], 1'b1};
            run_no++;
            if (run_no == 3) begin
                det_nov++;
                run_no = 0;
            end
        end else begin
            hist   = {hist[0], 1'b0};
            run_no = 0;
        end
    endtask

    // Checks n frame cycles (bits[n-1] first), then the done cycle and one idle cycle.
    task automatic expect_frame(input string tag, input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, ".out"}, 32'(out), 32'(bits[n-1-i]));
            check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".busy"}, 32'(busy), 32'd1);
            check({tag, ".done"}, 32'(done), 32'd0);
            check({tag, ".err"}, 32'(err), 32'd0);
            if (out_valid) feed_detector(out);
            step();
        end
        check({tag, ".done_pulse"}, 32'(done), 32'd1);
        check_quiet({tag, ".done_cyc"});
        check({tag, ".done_err"}, 32'(err), 32'd0);
        step();
        check({tag, ".idle_done"}, 32'(done), 32'd0);
        check_quiet({tag, ".idle"});
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;
        gap     = '0;
        hist    = 2'b00;
        run_no  = 0;
        det_ov  = 0;
        det_nov = 0;

        // Reset state.
        step();
        check_quiet("rst");
        check("rst.done", 32'(done), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        reset = 1'b0;
        step();
        check_quiet("idle0");
        check("idle0.err", 32'(err), 32'd0);

        // Single repetition of 111.
        send(8'h07, 4'd3, 4'd1, 4'd0);
        expect_frame("f07", 32'b111, 3);

        // Two repetitions of 101 with a two-cycle gap.
        send(8'h05, 4'd3, 4'd2, 4'd2);
        expect_frame("f05", 32'b101_00_101, 8);

        // Illegal operands: len=0, reps=0, len>PAT_W.
        send(8'hFF, 4'd0, 4'd1, 4'd0);
        check("len0.err", 32'(err), 32'd1);
        check_quiet("len0");
        step();
        check("len0.err_clr", 32'(err), 32'd0);
        check_quiet("len0.after");

        send(8'hFF, 4'd3, 4'd0, 4'd0);
        check("reps0.err", 32'(err), 32'd1);
        check_quiet("reps0");
        step();
        check("reps0.err_clr", 32'(err), 32'd0);

        send(8'hFF, 4'd9, 4'd1, 4'd0);
        check("len9.err", 32'(err), 32'd1);
        check_quiet("len9");
        step();
        check("len9.err_clr", 32'(err), 32'd0);

        // Start re-pulsed with new operands for the whole frame, including DONE.
        send(8'hB2, 4'd8, 4'd1, 4'd0);
        pattern = 8'h00;
        len     = 4'd4;
        reps    = 4'd1;
        start   = 1'b1;
        expect_frame("fB2", 32'b1011_0010, 8);
        start = 1'b0;

        // Reset during the second bit aborts the frame without done.
        send(8'hC3, 4'd8, 4'd1, 4'd0);
        check("abort.bit1", 32'(out), 32'd1);
        step();
        check("abort.bit2", 32'(out), 32'd1);
        reset = 1'b1;
        #1;
        check_quiet("abort.rst");
        check("abort.rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_quiet("abort.held");
        step();
        check("abort.no_done", 32'(done), 32'd0);
        check_quiet("abort.idle");
        send(8'h0D, 4'd4, 4'd2, 4'd1);
        expect_frame("f0D", 32'b1101_0_1101, 9);

        // Loopback into the 111 detector: nine consecutive ones.
        hist    = 2'b00;
        run_no  = 0;
        det_ov  = 0;
        det_nov = 0;
        send(8'h07, 4'd3, 4'd3, 4'd0);
        expect_frame("f07x3", 32'h1FF, 9);
        check("det.overlap", 32'(det_ov), 32'd7);
        check("det.nonoverlap", 32'(det_nov), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
